// File: rtl/mcu_pixel_bridge_if.sv
// Bundles the MCU register bus and the memory-manager handshake of mcu_pixel_bridge.
// The bridge uses the slave modport; the MCU/memory side uses master.
interface mcu_pixel_bridge_if #(
  parameter int X_WIDTH    = 9,
  parameter int Y_WIDTH    = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  mcu_cs;
  logic                  mcu_we;
  logic [2:0]            mcu_reg_sel;
  logic [DATA_WIDTH-1:0] mcu_data_in;
  logic [DATA_WIDTH-1:0] mcu_data_out;
  logic                  mcu_data_oe;
  logic [X_WIDTH-1:0]    mem_x;
  logic [Y_WIDTH-1:0]    mem_y;
  logic                  mem_write_request;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic                  mem_write_complete;
  logic                  mem_read_request;
  logic [DATA_WIDTH-1:0] mem_read_data;
  logic                  mem_read_complete;
  logic                  fifo_full;

  modport slave (
    input  mcu_cs, mcu_we, mcu_reg_sel, mcu_data_in,
    output mcu_data_out, mcu_data_oe,
    output mem_x, mem_y, mem_write_request, mem_write_data, mem_read_request, fifo_full,
    input  mem_write_complete, mem_read_data, mem_read_complete
  );

  modport master (
    output mcu_cs, mcu_we, mcu_reg_sel, mcu_data_in,
    input  mcu_data_out, mcu_data_oe,
    input  mem_x, mem_y, mem_write_request, mem_write_data, mem_read_request, fifo_full,
    output mem_write_complete, mem_read_data, mem_read_complete
  );
endinterface

// File: rtl/mcu_pixel_bridge.sv
// MCU register-bus to pixel-memory bridge: synchronises MCU strobes, queues pixel
// writes in a FIFO and drains them (plus read-backs) over request/complete handshakes.
module mcu_pixel_bridge #(
  parameter int X_WIDTH     = 9,
  parameter int Y_WIDTH     = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int X_MAX       = 319,
  parameter int Y_MAX       = 239,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic clock,
  input logic reset,
  mcu_pixel_bridge_if.slave bus
);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = X_WIDTH + Y_WIDTH + DATA_WIDTH;
  localparam int XH_W    = X_WIDTH - DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  logic [SYNC_STAGES-1:0]                 wr_sync_q, wr_sync_d, rd_sync_q, rd_sync_d;
  logic [SYNC_STAGES-1:0][2:0]            sel_sync_q, sel_sync_d;
  logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] data_sync_q, data_sync_d;
  logic                  wr_prev_q, wr_prev_d, rd_prev_q, rd_prev_d;
  logic [2:0]            cap_sel_q, cap_sel_d;
  logic [DATA_WIDTH-1:0] cap_data_q, cap_data_d;

  logic [X_WIDTH-1:0]    x_q, x_d, rd_x_q, rd_x_d;
  logic [Y_WIDTH-1:0]    y_q, y_d, rd_y_q, rd_y_d;
  logic                  auto_inc_q, auto_inc_d, row_wrap_q, row_wrap_d;
  logic                  overflow_q, overflow_d, read_valid_q, read_valid_d;
  logic                  read_pending_q, read_pending_d;
  logic [DATA_WIDTH-1:0] read_data_q, read_data_d;

  logic [ENTRY_W-1:0]    fifo_mem_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0]    fifo_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]        count_q, count_d;
  logic                  fifo_full_q, fifo_full_d;

  state_t                state_q, state_d;
  logic [X_WIDTH-1:0]    mem_x_q, mem_x_d;
  logic [Y_WIDTH-1:0]    mem_y_q, mem_y_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  mem_wreq_q, mem_wreq_d, mem_rreq_q, mem_rreq_d;

  logic wr_s, rd_s, wr_fall, rd_fall, enq, deq, read_issue, read_done;
  logic [DATA_WIDTH-1:0] xh_read, status_read;

  assign wr_s    = wr_sync_q[SYNC_STAGES-1];
  assign rd_s    = rd_sync_q[SYNC_STAGES-1];
  assign wr_fall = wr_prev_q & ~wr_s;
  assign rd_fall = rd_prev_q & ~rd_s;
  assign enq     = wr_fall && (cap_sel_q == 3'd3) && !fifo_full_q;

  // Sel/data are captured while the synchronised strobe is high so a commit on the
  // falling edge uses the last value seen alongside the strobe.
  always_comb begin
    wr_sync_d   = {wr_sync_q[SYNC_STAGES-2:0], bus.mcu_cs & ~bus.mcu_we};
    rd_sync_d   = {rd_sync_q[SYNC_STAGES-2:0], bus.mcu_cs & bus.mcu_we};
    sel_sync_d  = {sel_sync_q[SYNC_STAGES-2:0], bus.mcu_reg_sel};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], bus.mcu_data_in};
    wr_prev_d   = wr_s;
    rd_prev_d   = rd_s;
    cap_sel_d   = cap_sel_q;
    cap_data_d  = cap_data_q;
    if (wr_s || rd_s) begin
      cap_sel_d  = sel_sync_q[SYNC_STAGES-1];
      cap_data_d = data_sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    auto_inc_d   = auto_inc_q;
    row_wrap_d   = row_wrap_q;
    overflow_d   = overflow_q;
    read_valid_d = read_valid_q;
    read_data_d  = read_data_q;
    rd_x_d       = rd_x_q;
    rd_y_d       = rd_y_q;
    // Pending clears when the read is issued, so a trigger during flight queues another.
    read_pending_d = read_pending_q & ~read_issue;
    if (rd_fall && cap_sel_q == 3'd3) read_valid_d = 1'b0;
    if (rd_fall && cap_sel_q == 3'd5) overflow_d = 1'b0;
    if (read_done) begin
      read_valid_d = 1'b1;
      read_data_d  = bus.mem_read_data;
    end
    if (wr_fall) begin
      case (cap_sel_q)
        3'd0: x_d[DATA_WIDTH-1:0] = cap_data_q;
        3'd1: x_d[X_WIDTH-1:DATA_WIDTH] = cap_data_q[XH_W-1:0];
        3'd2: y_d = Y_WIDTH'(cap_data_q);
        3'd3: begin
          if (fifo_full_q) overflow_d = 1'b1;
          else if (auto_inc_q) begin
            if (x_q < X_WIDTH'(X_MAX)) x_d = x_q + X_WIDTH'(1);
            else begin
              x_d = '0;
              if (row_wrap_q) y_d = (y_q == Y_WIDTH'(Y_MAX)) ? '0 : y_q + Y_WIDTH'(1);
            end
          end
        end
        3'd4: begin
          auto_inc_d = cap_data_q[0];
          row_wrap_d = cap_data_q[1];
        end
        3'd6: begin
          read_pending_d = 1'b1;
          rd_x_d         = x_q;
          rd_y_d         = y_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (enq) begin
      fifo_mem_d[wr_ptr_q] = {x_q, y_q, cap_data_q};
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d     = count_q + (PTR_W+1)'(enq) - (PTR_W+1)'(deq);
    fifo_full_d = (count_d == (PTR_W+1)'(FIFO_DEPTH));
  end

  // Queued writes win over a pending read so read-back sees every earlier write.
  always_comb begin
    state_d     = state_q;
    mem_x_d     = mem_x_q;
    mem_y_d     = mem_y_q;
    mem_wdata_d = mem_wdata_q;
    mem_wreq_d  = mem_wreq_q;
    mem_rreq_d  = mem_rreq_q;
    deq         = 1'b0;
    read_issue  = 1'b0;
    read_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          {mem_x_d, mem_y_d, mem_wdata_d} = fifo_mem_q[rd_ptr_q];
          mem_wreq_d = 1'b1;
          deq        = 1'b1;
          state_d    = WRITE;
        end else if (read_pending_q) begin
          mem_x_d    = rd_x_q;
          mem_y_d    = rd_y_q;
          mem_rreq_d = 1'b1;
          read_issue = 1'b1;
          state_d    = READ;
        end
      end
      WRITE: if (bus.mem_write_complete) begin
        mem_wreq_d = 1'b0;
        state_d    = IDLE;
      end
      READ: if (bus.mem_read_complete) begin
        mem_rreq_d = 1'b0;
        read_done  = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_sync_q <= '0; rd_sync_q <= '0; sel_sync_q <= '0; data_sync_q <= '0;
      wr_prev_q <= 1'b0; rd_prev_q <= 1'b0; cap_sel_q <= '0; cap_data_q <= '0;
      x_q <= '0; y_q <= '0; rd_x_q <= '0; rd_y_q <= '0;
      auto_inc_q <= 1'b0; row_wrap_q <= 1'b0; overflow_q <= 1'b0;
      read_valid_q <= 1'b0; read_pending_q <= 1'b0; read_data_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
      wr_ptr_q <= '0; rd_ptr_q <= '0; count_q <= '0; fifo_full_q <= 1'b0;
      state_q <= IDLE; mem_x_q <= '0; mem_y_q <= '0; mem_wdata_q <= '0;
      mem_wreq_q <= 1'b0; mem_rreq_q <= 1'b0;
    end else begin
      wr_sync_q <= wr_sync_d; rd_sync_q <= rd_sync_d;
      sel_sync_q <= sel_sync_d; data_sync_q <= data_sync_d;
      wr_prev_q <= wr_prev_d; rd_prev_q <= rd_prev_d;
      cap_sel_q <= cap_sel_d; cap_data_q <= cap_data_d;
      x_q <= x_d; y_q <= y_d; rd_x_q <= rd_x_d; rd_y_q <= rd_y_d;
      auto_inc_q <= auto_inc_d; row_wrap_q <= row_wrap_d; overflow_q <= overflow_d;
      read_valid_q <= read_valid_d; read_pending_q <= read_pending_d; read_data_q <= read_data_d;
      fifo_mem_q <= fifo_mem_d;
      wr_ptr_q <= wr_ptr_d; rd_ptr_q <= rd_ptr_d; count_q <= count_d; fifo_full_q <= fifo_full_d;
      state_q <= state_d; mem_x_q <= mem_x_d; mem_y_q <= mem_y_d; mem_wdata_q <= mem_wdata_d;
      mem_wreq_q <= mem_wreq_d; mem_rreq_q <= mem_rreq_d;
    end
  end

  // Read mux decodes the raw select so the MCU sees data within its own bus cycle.
  always_comb begin
    xh_read                = '0;
    xh_read[XH_W-1:0]      = x_q[X_WIDTH-1:DATA_WIDTH];
    status_read            = '0;
    status_read[0]         = fifo_full_q;
    status_read[1]         = (count_q == '0);
    status_read[2]         = read_valid_q;
    status_read[3]         = overflow_q;
    status_read[4]         = (state_q != IDLE);
    case (bus.mcu_reg_sel)
      3'd0:    bus.mcu_data_out = x_q[DATA_WIDTH-1:0];
      3'd1:    bus.mcu_data_out = xh_read;
      3'd2:    bus.mcu_data_out = DATA_WIDTH'(y_q);
      3'd3:    bus.mcu_data_out = read_data_q;
      3'd4:    bus.mcu_data_out = {{(DATA_WIDTH-2){1'b0}}, row_wrap_q, auto_inc_q};
      3'd5:    bus.mcu_data_out = status_read;
      3'd7:    bus.mcu_data_out = '1;
      default: bus.mcu_data_out = '0;
    endcase
    if (reset) bus.mcu_data_out = '0;
  end

  assign bus.mcu_data_oe       = bus.mcu_cs & bus.mcu_we & ~reset;
  assign bus.mem_x             = mem_x_q;
  assign bus.mem_y             = mem_y_q;
  assign bus.mem_write_data    = mem_wdata_q;
  assign bus.mem_write_request = mem_wreq_q;
  assign bus.mem_read_request  = mem_rreq_q;
  assign bus.fifo_full         = fifo_full_q;
endmodule
